// File: rtl/note_player_pkg.sv
// Shared types and widths for the note player and its frequency ROM.
// No logic here; everything is compile-time constants.
package note_player_pkg;

  localparam int STATE_WIDTH     = 2;
  localparam int NOTE_WIDTH      = 6;
  localparam int DURATION_WIDTH  = 6;
  localparam int PHASE_WIDTH_DEF = 20;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/note_player_frequency_rom.sv
// Note number to phase step, registered output; 1 cycle read latency.
// Entry n = round(440 * 2^((n-49)/12) * 2^20 / 48000); entry 0 (rest) is 0.
module frequency_rom
  import note_player_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic [NOTE_WIDTH-1:0]  addr,
  output logic [PHASE_WIDTH-1:0] dout
);

  logic [19:0] entry;

  always_comb begin
    entry = '0;
    case (addr)
      6'd1:  entry = 20'd601;
      6'd2:  entry = 20'd636;
      6'd3:  entry = 20'd674;
      6'd4:  entry = 20'd714;
      6'd5:  entry = 20'd757;
      6'd6:  entry = 20'd802;
      6'd7:  entry = 20'd850;
      6'd8:  entry = 20'd900;
      6'd9:  entry = 20'd954;
      6'd10: entry = 20'd1010;
      6'd11: entry = 20'd1070;
      6'd12: entry = 20'd1134;
      6'd13: entry = 20'd1201;
      6'd14: entry = 20'd1273;
      6'd15: entry = 20'd1349;
      6'd16: entry = 20'd1429;
      6'd17: entry = 20'd1514;
      6'd18: entry = 20'd1604;
      6'd19: entry = 20'd1699;
      6'd20: entry = 20'd1800;
      6'd21: entry = 20'd1907;
      6'd22: entry = 20'd2021;
      6'd23: entry = 20'd2141;
      6'd24: entry = 20'd2268;
      6'd25: entry = 20'd2403;
      6'd26: entry = 20'd2546;
      6'd27: entry = 20'd2697;
      6'd28: entry = 20'd2858;
      6'd29: entry = 20'd3028;
      6'd30: entry = 20'd3208;
      6'd31: entry = 20'd3398;
      6'd32: entry = 20'd3600;
      6'd33: entry = 20'd3815;
      6'd34: entry = 20'd4041;
      6'd35: entry = 20'd4282;
      6'd36: entry = 20'd4536;
      6'd37: entry = 20'd4806;
      6'd38: entry = 20'd5092;
      6'd39: entry = 20'd5395;
      6'd40: entry = 20'd5715;
      6'd41: entry = 20'd6055;
      6'd42: entry = 20'd6415;
      6'd43: entry = 20'd6797;
      6'd44: entry = 20'd7201;
      6'd45: entry = 20'd7629;
      6'd46: entry = 20'd8083;
      6'd47: entry = 20'd8563;
      6'd48: entry = 20'd9072;
      6'd49: entry = 20'd9612;
      6'd50: entry = 20'd10184;
      6'd51: entry = 20'd10789;
      6'd52: entry = 20'd11431;
      6'd53: entry = 20'd12110;
      6'd54: entry = 20'd12830;
      6'd55: entry = 20'd13593;
      6'd56: entry = 20'd14402;
      6'd57: entry = 20'd15258;
      6'd58: entry = 20'd16165;
      6'd59: entry = 20'd17127;
      6'd60: entry = 20'd18145;
      6'd61: entry = 20'd19224;
      6'd62: entry = 20'd20367;
      6'd63: entry = 20'd21578;
      default: entry = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    dout <= PHASE_WIDTH'(entry);
  end

endmodule

// File: rtl/note_player.sv
// Plays one note: ROM step lookup, phase accumulator on sample strobes, beat countdown to note_done.
// Load-to-PLAY is 2 cycles; all outputs registered; no backpressure, strobes are never dropped.
module note_player
  import note_player_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play_enable,
  input  logic [NOTE_WIDTH-1:0]     note,
  input  logic [DURATION_WIDTH-1:0] duration,
  input  logic                      load_new_note,
  input  logic                      beat,
  input  logic                      generate_next_sample,
  output logic [ADDR_WIDTH-1:0]     sample_addr,
  output logic                      rest,
  output logic                      sample_ready,
  output logic                      note_done,
  output logic                      busy
);

  state_t                    state, state_nxt;
  logic [NOTE_WIDTH-1:0]     note_reg;
  logic [NOTE_WIDTH-1:0]     rom_addr;
  logic [DURATION_WIDTH-1:0] dur_reg;
  logic [DURATION_WIDTH-1:0] remaining;
  logic [PHASE_WIDTH-1:0]    phase;
  logic [PHASE_WIDTH-1:0]    step;
  logic [PHASE_WIDTH-1:0]    rom_dout;
  logic                      advance;
  logic                      rest_nxt;
  logic                      busy_nxt;
  logic                      done_nxt;

  assign advance     = (state == PLAY) && play_enable;
  assign sample_addr = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];

  // The ROM must see the incoming note on the load edge so its data is ready during LOAD.
  assign rom_addr = load_new_note ? note : note_reg;

  frequency_rom #(
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_frequency_rom (
    .clk  (clk),
    .addr (rom_addr),
    .dout (rom_dout)
  );

  always_comb begin
    state_nxt = state;
    if (load_new_note) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        LOAD: state_nxt = (dur_reg == '0) ? DONE : PLAY;
        PLAY: if (advance && beat && remaining <= DURATION_WIDTH'(1)) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    rest_nxt = !((state_nxt == PLAY) && play_enable && (note_reg != '0));
    busy_nxt = (state_nxt == LOAD) || (state_nxt == PLAY);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      note_reg  <= '0;
      dur_reg   <= '0;
      remaining <= '0;
      step      <= '0;
      phase     <= '0;
    end else begin
      state <= state_nxt;
      if (load_new_note) begin
        note_reg <= note;
        dur_reg  <= duration;
        phase    <= '0;
      end else begin
        if (state == LOAD) begin
          step      <= rom_dout;
          remaining <= dur_reg;
        end
        if (advance && beat && remaining > DURATION_WIDTH'(1)) begin
          remaining <= remaining - DURATION_WIDTH'(1);
        end
        if (advance && generate_next_sample) begin
          phase <= phase + step;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_ready <= 1'b0;
      note_done    <= 1'b0;
      busy         <= 1'b0;
      rest         <= 1'b1;
    end else begin
      sample_ready <= generate_next_sample;
      note_done    <= done_nxt;
      busy         <= busy_nxt;
      rest         <= rest_nxt;
    end
  end

endmodule

// File: doc/note_player.md
# note_player

Plays one note at a time: the stage directly downstream of the song sequencer. It accepts a note number and a duration, looks up a phase step in a frequency ROM, and advances a phase accumulator on every sample strobe. It counts beats until the duration expires, then pulses `note_done` back to the sequencer. Its phase output addresses the existing waveform lookup stage.

## Interface
Parameters:
- PHASE_WIDTH, 20: phase accumulator and step width.
- ADDR_WIDTH, 10: waveform address width; this is the top bits of the phase.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- play_enable  in  1  level. Low freezes beat counting and phase advance.
- note  in  6  note number; 0 = rest.
- duration  in  6  note length in beats.
- load_new_note  in  1  one-cycle pulse; samples `note`/`duration` on the same edge.
- beat  in  1  one-cycle tempo pulse (48 per second).
- generate_next_sample  in  1  one-cycle sample-rate strobe (48 kHz).
- sample_addr  out  ADDR_WIDTH  phase[PHASE_WIDTH-1 -: ADDR_WIDTH].
- rest  out  1  high when the current output must be silence.
- sample_ready  out  1  one-cycle pulse; `sample_addr`/`rest` are updated.
- note_done  out  1  one-cycle pulse when the duration expires.
- busy  out  1  high in LOAD and PLAY.

## Operation
- FSM states:
  - IDLE=2'd0
  - LOAD=2'd1
  - PLAY=2'd2
  - DONE=2'd3
- Reset values:
  - state IDLE
  - phase, step, remaining, note_reg all 0
  - sample_ready, note_done, busy = 0
  - rest = 1
- load_new_note in any state:
  - latch note and duration; clear phase to 0.
  - present the latched note to the ROM.
  - next state is LOAD.
  - Load has priority over every other transition.
- LOAD (exactly 1 cycle, ROM latency):
  - step <= ROM data; remaining <= duration.
  - Next state is DONE if duration == 0, else PLAY.
  - beat is ignored in LOAD.
- PLAY with play_enable=1:
  - On beat: if remaining == 1, go to DONE; else remaining -= 1.
  - On generate_next_sample: phase <= phase + step, modulo 2^PHASE_WIDTH, wrap silently.
- PLAY with play_enable=0: state, remaining and phase are all held.
- DONE: `note_done` is high for this one cycle; next state is IDLE, unless a load is pending.
- A load during PLAY aborts the current note. No note_done is issued for the aborted note.
- A load in the DONE cycle: note_done is still asserted that cycle, and the next state is LOAD.
- Sample strobes:
  - Every generate_next_sample produces sample_ready on the next cycle, in every state.
  - This keeps the downstream sample rate constant.
  - rest = 1 unless the state is PLAY, play_enable=1 and note_reg != 0.
- Frequency ROM:
  - 64 entries of PHASE_WIDTH bits; entry 0 = 0.
  - Entry n = round(440 · 2^((n-49)/12) · 2^20 / 48000).
  - Entry 49 = 9612.
- The beat counter is 6 bits and never underflows: the DONE transition happens at 1.

## Timing
- load_new_note at edge T:
  - LOAD during cycle T+1.
  - PLAY from T+2; the first beat counted is at T+2 or later.
- Beats:
  - duration=N>0: the N-th counted beat at edge B puts the block in DONE during B+1.
  - note_done is high exactly that cycle.
- duration=0: note_done is high in cycle T+2.
- Samples:
  - generate_next_sample at edge S: phase updates at S.
  - sample_addr and sample_ready are registered; both are valid in cycle S+1.
- Reset asserted mid-note: all outputs go to reset values immediately (asynchronous), and no note_done is issued.
- Outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package/header holds:
  - state encodings and their width (2)
  - NOTE_WIDTH=6, DURATION_WIDTH=6
  - PHASE_WIDTH default
- Sub-module `frequency_rom`: synchronous 64×PHASE_WIDTH ROM (clk, addr[5:0], dout).
- Registers use the team's async-reset flop cell, with the active-low reset.

## Test plan
- Note 49, duration 3, beat every 10 cycles → note_done pulses once, one cycle after the 3rd beat; busy falls the same cycle.
- Note 49, four strobes in PLAY → phase=38448, sample_addr=37, four sample_ready pulses, rest=0.
- Note 0, duration 2 → rest=1 on every sample_ready, phase stays 0, note_done after 2 beats.
- play_enable dropped for 5 beats mid-note (duration 4) → remaining and phase frozen, rest=1; note_done after 4 enabled beats in total.
- load_new_note (note 10, duration 5) arrives during PLAY with remaining=2 → no note_done for the old note; the new note runs 5 beats, and phase restarts from 0.
- Duration 0 → note_done at T+2; reset asserted in PLAY → state IDLE and all outputs at reset values within the same cycle.
